// File: rtl/cursor_mv_if.sv
// Link between the cursor sequencer and the registered grid-movement block.
// The master drives the current position and strobes; the slave returns the next position.
interface cursor_mv_if #(
    parameter int unsigned CW = 3
) ();
    logic [CW-1:0] mv_iact;
    logic [CW-1:0] mv_jact;
    logic          mv_up;
    logic          mv_down;
    logic          mv_left;
    logic          mv_right;
    logic [CW-1:0] mv_inext;
    logic [CW-1:0] mv_jnext;
    logic          mv_valid;

    modport master (
        output mv_iact, mv_jact, mv_up, mv_down, mv_left, mv_right,
        input  mv_inext, mv_jnext, mv_valid
    );

    modport slave (
        input  mv_iact, mv_jact, mv_up, mv_down, mv_left, mv_right,
        output mv_inext, mv_jnext, mv_valid
    );
endinterface

// File: rtl/cursor_ctrl.sv
// Board cursor sequencer: edge-detects buttons, issues moves to the movement block,
// commits its one-cycle-late result and provides hold-to-repeat and select pulses.
module cursor_ctrl #(
    parameter int unsigned CW           = 3,
    parameter int unsigned START_I      = 0,
    parameter int unsigned START_J      = 0,
    parameter int unsigned REPEAT_DELAY = 8,
    parameter int unsigned REPEAT_RATE  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable_i,
    input  logic          btn_up_i,
    input  logic          btn_down_i,
    input  logic          btn_left_i,
    input  logic          btn_right_i,
    input  logic          btn_sel_i,
    cursor_mv_if.master   mv,
    output logic [CW-1:0] cur_i_o,
    output logic [CW-1:0] cur_j_o,
    output logic          moved_o,
    output logic          blocked_o,
    output logic          sel_pulse_o,
    output logic          busy_o
);

    localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned CntW   = $clog2(RepMax + 1);
    localparam logic [CntW-1:0] DelayLast = CntW'(REPEAT_DELAY - 1);
    localparam logic [CntW-1:0] RateLast  = CntW'(REPEAT_RATE - 1);
    localparam logic [CntW-1:0] CntMax    = '1;

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StCommit, StHold} state_e;

    state_e        state_q, state_d;
    logic [3:0]    dir_q, dir_d;
    logic          first_q, first_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cur_i_q, cur_i_d, cur_j_q, cur_j_d;
    logic [CW-1:0] nxt_i_q, nxt_j_q;
    logic          nxt_v_q;
    logic          moved_q, moved_d, blocked_q, blocked_d;
    logic [3:0]    btn_q;
    logic          sel_q, sel_pend_q, sel_pend_d, sel_pulse_q, sel_pulse_d;

    logic [3:0] btn_now;
    logic [3:0] dir_now;
    logic       dir_rise;
    logic       sel_rise;
    logic       strobe_on;
    logic       sel_open;

    // Bit order {up, down, left, right}; opposite presses cancel on their axis.
    assign btn_now  = {btn_up_i, btn_down_i, btn_left_i, btn_right_i};
    assign dir_now  = {btn_up_i & ~btn_down_i, btn_down_i & ~btn_up_i,
                       btn_left_i & ~btn_right_i, btn_right_i & ~btn_left_i};
    assign dir_rise = |(btn_now & ~btn_q);
    assign sel_rise = btn_sel_i & ~sel_q & enable_i;

    assign strobe_on = (state_q == StIssue) || (state_q == StWait);
    assign sel_open  = (state_q == StIdle) || (state_q == StHold);

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        first_d   = first_q;
        cnt_d     = cnt_q;
        cur_i_d   = cur_i_q;
        cur_j_d   = cur_j_q;
        moved_d   = 1'b0;
        blocked_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable_i && dir_rise && (dir_now != 4'b0)) begin
                    dir_d   = dir_now;
                    first_d = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: state_d = StWait;
            StWait:  state_d = StCommit;
            StCommit: begin
                if (nxt_v_q && ({nxt_i_q, nxt_j_q} != {cur_i_q, cur_j_q})) begin
                    cur_i_d = nxt_i_q;
                    cur_j_d = nxt_j_q;
                    moved_d = 1'b1;
                end else begin
                    blocked_d = 1'b1;
                end
                cnt_d   = '0;
                state_d = StHold;
            end
            StHold: begin
                if (!enable_i || (dir_now == 4'b0)) begin
                    state_d = StIdle;
                end else if (dir_now != dir_q) begin
                    dir_d   = dir_now;
                    first_d = 1'b1;
                    cnt_d   = '0;
                    state_d = StIssue;
                end else if (cnt_q >= (first_q ? DelayLast : RateLast)) begin
                    first_d = 1'b0;
                    cnt_d   = '0;
                    state_d = StIssue;
                end else if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A select seen while a move is in flight waits (depth 1) until IDLE/HOLD.
    always_comb begin
        sel_pulse_d = 1'b0;
        sel_pend_d  = sel_pend_q | sel_rise;
        if (sel_open) begin
            sel_pulse_d = sel_rise | sel_pend_q;
            sel_pend_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            dir_q       <= 4'b0;
            first_q     <= 1'b0;
            cnt_q       <= '0;
            cur_i_q     <= CW'(START_I);
            cur_j_q     <= CW'(START_J);
            nxt_i_q     <= '0;
            nxt_j_q     <= '0;
            nxt_v_q     <= 1'b0;
            moved_q     <= 1'b0;
            blocked_q   <= 1'b0;
            btn_q       <= 4'b0;
            sel_q       <= 1'b0;
            sel_pend_q  <= 1'b0;
            sel_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            first_q     <= first_d;
            cnt_q       <= cnt_d;
            cur_i_q     <= cur_i_d;
            cur_j_q     <= cur_j_d;
            moved_q     <= moved_d;
            blocked_q   <= blocked_d;
            btn_q       <= btn_now;
            sel_q       <= btn_sel_i;
            sel_pend_q  <= sel_pend_d;
            sel_pulse_q <= sel_pulse_d;
            if (state_q == StWait) begin
                nxt_i_q <= mv.mv_inext;
                nxt_j_q <= mv.mv_jnext;
                nxt_v_q <= mv.mv_valid;
            end
        end
    end

    assign mv.mv_iact  = cur_i_q;
    assign mv.mv_jact  = cur_j_q;
    assign mv.mv_up    = strobe_on & dir_q[3];
    assign mv.mv_down  = strobe_on & dir_q[2];
    assign mv.mv_left  = strobe_on & dir_q[1];
    assign mv.mv_right = strobe_on & dir_q[0];

    assign cur_i_o     = cur_i_q;
    assign cur_j_o     = cur_j_q;
    assign moved_o     = moved_q;
    assign blocked_o   = blocked_q;
    assign sel_pulse_o = sel_pulse_q;
    assign busy_o      = strobe_on;

endmodule

// File: tb/tb_cursor_ctrl.sv
// Scoreboard bench for cursor_ctrl with a registered clamping movement model.
module tb_cursor_ctrl;
    localparam int unsigned CW = 3;
    localparam int unsigned RD = 8;
    localparam int unsigned RR = 4;

    typedef enum logic [1:0] {EvMoved, EvBlocked, EvSel} ev_e;
    typedef struct packed {
        ev_e           kind;
        logic [CW-1:0] i;
        logic [CW-1:0] j;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, sel = 1'b0;
    logic ovr = 1'b0, inval = 1'b0;
    logic [CW-1:0] ovr_i = '0, ovr_j = '0;
    logic [CW-1:0] cur_i, cur_j;
    logic moved, blocked, sel_pulse, busy;
    logic [3:0] strobes;
    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    cursor_mv_if #(.CW(CW)) mv_bus ();

    cursor_ctrl #(
        .CW(CW), .START_I(0), .START_J(0), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk(clk), .rst(rst), .enable_i(en),
        .btn_up_i(up), .btn_down_i(down), .btn_left_i(left), .btn_right_i(right),
        .btn_sel_i(sel), .mv(mv_bus),
        .cur_i_o(cur_i), .cur_j_o(cur_j), .moved_o(moved), .blocked_o(blocked),
        .sel_pulse_o(sel_pulse), .busy_o(busy)
    );

    always #5 clk = ~clk;

    assign strobes = {mv_bus.mv_up, mv_bus.mv_down, mv_bus.mv_left, mv_bus.mv_right};

    function automatic logic [CW-1:0] next_coord(input logic [CW-1:0] c, input logic dec,
                                                 input logic inc);
        if (dec && !inc && c != '0) return c - 1'b1;
        if (inc && !dec && c != '1) return c + 1'b1;
        return c;
    endfunction

    // Ideal movement block: clamps at the board edges, result one cycle after the strobes.
    always @(posedge clk) begin
        mv_bus.mv_valid <= ~inval;
        if (ovr) begin
            mv_bus.mv_inext <= ovr_i;
            mv_bus.mv_jnext <= ovr_j;
        end else begin
            mv_bus.mv_inext <= next_coord(mv_bus.mv_iact, mv_bus.mv_up, mv_bus.mv_down);
            mv_bus.mv_jnext <= next_coord(mv_bus.mv_jact, mv_bus.mv_left, mv_bus.mv_right);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic expect_ev(input ev_e kind, input int i, input int j);
        exp_q.push_back('{kind: kind, i: CW'(i), j: CW'(j)});
    endtask

    task automatic pop_check(input ev_e kind);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse: got %s at (%0d,%0d) required none",
                     kind.name(), cur_i, cur_j);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind || e.i != cur_i || e.j != cur_j) begin
            errors++;
            $display("FAIL event: got %s (%0d,%0d) required %s (%0d,%0d)",
                     kind.name(), cur_i, cur_j, e.kind.name(), e.i, e.j);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (moved) pop_check(EvMoved);
            if (blocked) pop_check(EvBlocked);
            if (sel_pulse) pop_check(EvSel);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // d = {up, down, left, right}; held for exactly one sampling edge.
    task automatic tap(input logic [3:0] d, input int settle);
        {up, down, left, right} = d;
        step();
        {up, down, left, right} = 4'b0;
        repeat (settle) step();
    endtask

    initial begin
        repeat (3) step();
        check("reset_cur_i", 32'(cur_i), 0);
        check("reset_cur_j", 32'(cur_j), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_strobes", 32'(strobes), 0);
        check("reset_pulses", 32'({moved, blocked, sel_pulse}), 0);
        rst = 1'b0;
        en  = 1'b1;
        step();

        // Single right press from (0,0): busy for ISSUE and WAIT, moved 3 edges later.
        expect_ev(EvMoved, 0, 1);
        right = 1'b1;
        step();
        check("t1_issue_busy", 32'(busy), 1);
        check("t1_issue_strobe", 32'(strobes), 32'h1);
        check("t1_iact", 32'(mv_bus.mv_iact), 0);
        right = 1'b0;
        step();
        check("t1_wait_busy", 32'(busy), 1);
        check("t1_wait_strobe", 32'(strobes), 32'h1);
        step();
        check("t1_commit_busy", 32'(busy), 0);
        check("t1_commit_cur_j", 32'(cur_j), 0);
        step();
        check("t1_moved", 32'(moved), 1);
        check("t1_cur_j", 32'(cur_j), 1);
        check("t1_jact", 32'(mv_bus.mv_jact), 1);
        repeat (4) step();

        // Jump to the corner, then a down press is clamped and reported as blocked.
        ovr = 1'b1; ovr_i = 3'd7; ovr_j = 3'd7;
        expect_ev(EvMoved, 7, 7);
        tap(4'b0100, 6);
        ovr = 1'b0;
        expect_ev(EvBlocked, 7, 7);
        tap(4'b0100, 3);
        check("t2_blocked", 32'(blocked), 1);
        check("t2_not_moved", 32'(moved), 0);
        check("t2_cur", 32'({cur_i, cur_j}), 32'({3'd7, 3'd7}));
        repeat (3) step();

        // Diagonal up+left is one move with both strobes.
        expect_ev(EvMoved, 6, 6);
        {up, left} = 2'b11;
        step();
        check("t3_diag_strobes", 32'(strobes), 32'hA);
        {up, left} = 2'b00;
        repeat (6) step();

        // Illegal move reported by the movement block.
        inval = 1'b1;
        expect_ev(EvBlocked, 6, 6);
        tap(4'b0100, 6);
        inval = 1'b0;

        // Back to origin, then hold right: first move, one after RD, one after RR.
        ovr = 1'b1; ovr_i = 3'd0; ovr_j = 3'd0;
        expect_ev(EvMoved, 0, 0);
        tap(4'b1000, 6);
        ovr = 1'b0;
        expect_ev(EvMoved, 0, 1);
        expect_ev(EvMoved, 0, 2);
        expect_ev(EvMoved, 0, 3);
        right = 1'b1;
        repeat (3 + RD + 2 * RR) step();
        right = 1'b0;
        repeat (16) step();
        check("t4_cur_j", 32'(cur_j), 3);
        check("t4_idle", 32'(busy), 0);

        // Opposite presses cancel.
        {up, down} = 2'b11;
        step();
        check("t5_cancel_busy", 32'(busy), 0);
        check("t5_cancel_strobes", 32'(strobes), 0);
        step();
        check("t5_cancel_busy2", 32'(busy), 0);
        {up, down} = 2'b00;
        step();

        // Select pressed during WAIT comes out after the commit with the new cursor.
        expect_ev(EvMoved, 0, 4);
        expect_ev(EvSel, 0, 4);
        right = 1'b1;
        step();
        right = 1'b0;
        step();
        sel = 1'b1;
        step();
        sel = 1'b0;
        repeat (6) step();

        // Select in IDLE.
        expect_ev(EvSel, 0, 4);
        sel = 1'b1;
        step();
        sel = 1'b0;
        repeat (3) step();

        // Reset during WAIT aborts the move.
        left = 1'b1;
        step();
        left = 1'b0;
        step();
        check("t6_in_wait", 32'(busy), 1);
        rst = 1'b1;
        step();
        check("t6_rst_cur", 32'({cur_i, cur_j}), 0);
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_strobes", 32'(strobes), 0);
        check("t6_rst_pulses", 32'({moved, blocked, sel_pulse}), 0);
        rst = 1'b0;
        step();

        // Disabled: presses and selects are ignored.
        en = 1'b0;
        right = 1'b1;
        sel = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("t7_dis_busy", 32'(busy), 0);
            check("t7_dis_strobes", 32'(strobes), 0);
        end
        right = 1'b0;
        sel = 1'b0;
        repeat (3) step();
        en = 1'b1;
        repeat (3) step();
        check("t7_cur", 32'({cur_i, cur_j}), 0);
        check("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
